// File: rtl/memcic_sched_if.sv
// Bus bundle between the channel-sharing scheduler, its requesters and the shared CIC engine.
// The scheduler takes the slave view; whatever surrounds it takes the master view.
interface memcic_sched_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
);
  logic [NCH-1:0]    in_strobe;
  logic [24*NCH-1:0] in_data;
  logic              cic_strobe;
  logic [23:0]       cic_data;
  logic [CW-1:0]     cic_chan;
  logic              cic_out_strobe;
  logic [23:0]       cic_out_data;
  logic [NCH-1:0]    out_strobe;
  logic [23:0]       out_data;
  logic [NCH-1:0]    overrun;
  logic              clear_overrun;

  modport master (
    output in_strobe, in_data, cic_out_strobe, cic_out_data, clear_overrun,
    input  cic_strobe, cic_data, cic_chan, out_strobe, out_data, overrun
  );

  modport slave (
    input  in_strobe, in_data, cic_out_strobe, cic_out_data, clear_overrun,
    output cic_strobe, cic_data, cic_chan, out_strobe, out_data, overrun
  );
endinterface

// File: rtl/memcic_sched.sv
// Round-robin scheduler sharing one memory-based CIC decimator between NCH sample streams.
// Strobes to the engine are spaced at least GAP cycles apart; outputs are routed by channel tag.
module memcic_sched #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = 2,
  parameter int unsigned STAGES = 11,
  parameter int unsigned GAP    = 2 * STAGES + 5
) (
  input logic           clock,
  input logic           reset_n,
  memcic_sched_if.slave bus
);
  localparam int unsigned GW = (GAP > 2) ? $clog2(GAP) : 1;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                 state_q, state_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [CW-1:0]          rr_q, rr_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [NCH-1:0][23:0]   hold_q, hold_d;
  logic                   cic_strobe_q, cic_strobe_d;
  logic [23:0]            cic_data_q, cic_data_d;
  logic [CW-1:0]          cic_chan_q, cic_chan_d;
  logic [NCH-1:0]         out_strobe_q, out_strobe_d;
  logic [23:0]            out_data_q, out_data_d;
  logic [NCH-1:0]         overrun_q, overrun_d;

  logic                   grant;
  logic [CW-1:0]          gnt_idx;
  logic [CW:0]            idx;

  // First pending channel at or after rr_q, wrapping at NCH-1.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      idx = {1'b0, rr_q} + (CW + 1)'(k);
      if (idx >= (CW + 1)'(NCH)) idx = idx - (CW + 1)'(NCH);
      if (!grant && pend_q[idx[CW-1:0]]) begin
        grant   = 1'b1;
        gnt_idx = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    rr_d         = rr_q;
    gap_d        = gap_q;
    hold_d       = hold_q;
    cic_strobe_d = 1'b0;
    cic_data_d   = cic_data_q;
    cic_chan_d   = cic_chan_q;
    out_strobe_d = '0;
    out_data_d   = out_data_q;
    overrun_d    = bus.clear_overrun ? '0 : overrun_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d         = StWait;
          cic_strobe_d    = 1'b1;
          cic_data_d      = hold_q[gnt_idx];
          cic_chan_d      = gnt_idx;
          pend_d[gnt_idx] = 1'b0;
          rr_d            = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
          // WAIT lasts GAP-1 cycles so the next IDLE grant lands exactly GAP after this strobe.
          gap_d           = GW'(GAP - 2);
        end
      end
      StWait: begin
        if (bus.cic_out_strobe) begin
          out_strobe_d[cic_chan_q] = 1'b1;
          out_data_d               = bus.cic_out_data;
        end
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // pend_d already reflects this cycle's grant, so a granted channel never flags overrun.
    for (int i = 0; i < int'(NCH); i++) begin
      if (bus.in_strobe[i]) begin
        if (pend_d[i]) overrun_d[i] = 1'b1;
        pend_d[i] = 1'b1;
        hold_d[i] = bus.in_data[24*i +: 24];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      rr_q         <= '0;
      gap_q        <= '0;
      hold_q       <= '0;
      cic_strobe_q <= 1'b0;
      cic_data_q   <= '0;
      cic_chan_q   <= '0;
      out_strobe_q <= '0;
      out_data_q   <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      rr_q         <= rr_d;
      gap_q        <= gap_d;
      hold_q       <= hold_d;
      cic_strobe_q <= cic_strobe_d;
      cic_data_q   <= cic_data_d;
      cic_chan_q   <= cic_chan_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.cic_strobe = cic_strobe_q;
  assign bus.cic_data   = cic_data_q;
  assign bus.cic_chan   = cic_chan_q;
  assign bus.out_strobe = out_strobe_q;
  assign bus.out_data   = out_data_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_memcic_sched.sv
// Randomized bench for memcic_sched against a timestamp-based reference of the scheduling rules.
module tb_memcic_sched;
  localparam int unsigned NCH    = 4;
  localparam int unsigned CW     = 2;
  localparam int unsigned STAGES = 11;
  localparam int unsigned GAP    = 2 * STAGES + 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  memcic_sched_if #(.NCH(NCH), .CW(CW)) bus ();

  memcic_sched #(.NCH(NCH), .CW(CW), .STAGES(STAGES), .GAP(GAP)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: pending samples plus the cycle of the last engine strobe.
  bit             known    = 1'b0;
  int             cyc      = 0;
  int             last_iss = -1000;
  int             rr       = 0;
  bit             pend[NCH];
  logic [23:0]    hold[NCH];
  logic           e_cs;
  logic           e_cd_chk;
  logic [23:0]    e_cd;
  int             e_cc;
  logic [NCH-1:0] e_os;
  logic [23:0]    e_od;
  logic [NCH-1:0] e_ov;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      pend[i] = 1'b0;
      hold[i] = '0;
    end
    last_iss = -1000;
    rr       = 0;
    e_cs     = 1'b0;
    e_cd_chk = 1'b1;
    e_cd     = '0;
    e_cc     = 0;
    e_os     = '0;
    e_od     = '0;
    e_ov     = '0;
    known    = 1'b1;
  endtask

  task automatic step(input logic [NCH-1:0] stb, input logic [24*NCH-1:0] data,
                      input logic clr, input logic ostb, input logic [23:0] odata,
                      input logic rst_n);
    bit granted;
    int g;
    int c;
    bit in_wait;
    @(negedge clock);
    if (known) begin
      check_eq("cic_strobe", 32'(bus.cic_strobe), 32'(e_cs));
      if (e_cd_chk) check_eq("cic_data", 32'(bus.cic_data), 32'(e_cd));
      check_eq("cic_chan", 32'(bus.cic_chan), 32'(e_cc));
      check_eq("out_strobe", 32'(bus.out_strobe), 32'(e_os));
      check_eq("out_data", 32'(bus.out_data), 32'(e_od));
      check_eq("overrun", 32'(bus.overrun), 32'(e_ov));
    end
    reset_n            = rst_n;
    bus.in_strobe      = stb;
    bus.in_data        = data;
    bus.clear_overrun  = clr;
    bus.cic_out_strobe = ostb;
    bus.cic_out_data   = odata;

    if (!rst_n) begin
      model_reset();
    end else begin
      // The engine is busy from the strobe cycle until GAP-1 cycles later.
      in_wait = (cyc >= last_iss) && (cyc <= last_iss + int'(GAP) - 2);
      e_os = '0;
      if (ostb && in_wait) begin
        e_os = NCH'(1) << e_cc;
        e_od = odata;
      end
      granted = 1'b0;
      g       = 0;
      if (cyc + 1 >= last_iss + int'(GAP)) begin
        for (int k = 0; k < int'(NCH); k++) begin
          c = (rr + k) % int'(NCH);
          if (!granted && pend[c]) begin
            granted = 1'b1;
            g       = c;
          end
        end
      end
      e_cs     = granted;
      e_cd_chk = granted;
      if (granted) begin
        e_cd     = hold[g];
        e_cc     = g;
        pend[g]  = 1'b0;
        rr       = (g + 1) % int'(NCH);
        last_iss = cyc + 1;
      end
      if (clr) e_ov = '0;
      for (int i = 0; i < int'(NCH); i++) begin
        if (stb[i]) begin
          if (pend[i]) e_ov[i] = 1'b1;
          pend[i] = 1'b1;
          hold[i] = data[24*i +: 24];
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [24*NCH-1:0] rnd_data();
    logic [24*NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[24*i +: 24] = 24'($urandom);
    return r;
  endfunction

  function automatic logic [NCH-1:0] rnd_stb(input int unsigned pdiv);
    logic [NCH-1:0] r;
    for (int i = 0; i < int'(NCH); i++) r[i] = ($urandom_range(pdiv - 1) == 0);
    return r;
  endfunction

  initial begin
    int unsigned pdiv;
    bus.in_strobe      = '0;
    bus.in_data        = '0;
    bus.clear_overrun  = 1'b0;
    bus.cic_out_strobe = 1'b0;
    bus.cic_out_data   = '0;

    repeat (2) step('0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(8);
    // Single sample on channel 2.
    step(4'b0100, {24'h0, 24'h123456, 48'h0}, 1'b0, 1'b0, '0, 1'b1);
    idle(40);
    // All channels at once from rr_ptr=3 after the previous grant.
    step(4'b1111, {24'h333333, 24'h222222, 24'h111111, 24'h0a0a0a}, 1'b0, 1'b0, '0, 1'b1);
    idle(120);
    // Channel 1 queued behind channel 0, then overwritten.
    step(4'b0011, {48'h0, 24'h1a1a1a, 24'h0b0b0b}, 1'b0, 1'b0, '0, 1'b1);
    idle(4);
    step(4'b0010, {48'h0, 24'h1c1c1c, 24'h0}, 1'b0, 1'b0, '0, 1'b1);
    idle(60);
    step('0, '0, 1'b1, 1'b0, '0, 1'b1);
    idle(5);
    // Routed engine output 20 cycles after a channel-3 issue, then a stray one in IDLE.
    step(4'b1000, {24'h777777, 72'h0}, 1'b0, 1'b0, '0, 1'b1);
    idle(21);
    step('0, '0, 1'b0, 1'b1, 24'hfedcba, 1'b1);
    idle(10);
    step('0, '0, 1'b0, 1'b1, 24'h555555, 1'b1);
    idle(3);
    // Reset five cycles into a WAIT window.
    step(4'b0001, {72'h0, 24'h0c0c0c}, 1'b0, 1'b0, '0, 1'b1);
    idle(6);
    step('0, '0, 1'b0, 1'b0, '0, 1'b0);
    step(4'b0010, {48'h0, 24'h1d1d1d, 24'h0}, 1'b0, 1'b0, '0, 1'b1);
    idle(5);

    for (int ph = 0; ph < 3; ph++) begin
      pdiv = (ph == 0) ? 150 : ((ph == 1) ? 40 : 12);
      for (int n = 0; n < 2000; n++) begin
        step(rnd_stb(pdiv), rnd_data(), ($urandom_range(59) == 0), ($urandom_range(7) == 0),
             24'($urandom), ($urandom_range(1499) != 0));
      end
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/memcic_sched.md
Name: memcic_sched

Overview:
- Round-robin scheduler that shares one memory-based CIC decimator engine between NCH independent 24-bit sample streams, for example several receiver I/Q paths.
- Latches one pending sample per channel and issues samples to the engine no faster than its minimum strobe spacing.
- Drives a channel tag that the engine uses as upper RAM address bits, so each channel keeps its own integrator/comb state.
- Routes each decimated output back to the channel that produced it.

Parameters:
- NCH, 4, number of requester channels (2..8).
- CW, 2, channel tag width; must satisfy 2^CW >= NCH.
- STAGES, 11, CIC stage count of the shared engine.
- GAP, 2*STAGES+5, minimum clock cycles between engine strobes.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active low.
- in_strobe  in  NCH  per-channel sample strobe, 1-cycle pulse.
- in_data  in  24*NCH  signed samples; channel i occupies bits [24*i+23:24*i].
- cic_strobe  out  1  engine input strobe, 1-cycle pulse.
- cic_data  out  24  sample presented to the engine; valid when cic_strobe=1.
- cic_chan  out  CW  channel currently owning the engine.
- cic_out_strobe  in  1  engine output-valid pulse.
- cic_out_data  in  24  engine decimated output.
- out_strobe  out  NCH  per-channel decimated-output pulse.
- out_data  out  24  decimated output shared by all channels; qualified by out_strobe.
- overrun  out  NCH  sticky per-channel sample-loss flag.
- clear_overrun  in  1  clears all overrun bits.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, all pending bits=0, rr_ptr=0, gap counter=0.
  - Outputs: cic_strobe=0, cic_data=0, cic_chan=0, out_strobe=0, out_data=0, overrun=0.
  - Reset mid-WAIT abandons the issued sample with no output routed. The engine is not reset by this block.
- Capture:
  - in_strobe[i]=1 loads hold[i] with that channel's in_data and sets pending[i].
  - If pending[i] is already 1 and channel i is not granted in the same cycle: hold[i] is overwritten with the newest sample and overrun[i] is set.
  - A grant and a new in_strobe on the same channel in the same cycle: the granted (old) sample is issued, the new sample is held, pending[i] stays 1, no overrun.
- State machine, two states:
  - IDLE:
    - If any pending bit is set, grant the first pending channel searching from rr_ptr upward with wrap at NCH-1 -> 0.
    - Register cic_strobe=1, cic_data=hold[g], cic_chan=g. Clear pending[g], set rr_ptr=(g+1) mod NCH, go to WAIT.
  - WAIT:
    - cic_strobe=0; cic_chan holds g for the entire WAIT.
    - Return to IDLE so that the earliest next cic_strobe occurs exactly GAP cycles after the previous one.
- Timing requirements:
  - Idle-engine latency: in_strobe in cycle t gives cic_strobe in cycle t+2.
  - Two cic_strobe pulses are never less than GAP cycles apart.
  - cic_chan never changes between a cic_strobe and the end of its GAP window.
- Output routing:
  - cic_out_strobe=1 during WAIT: next cycle out_strobe[cic_chan]=1 for one cycle and out_data=cic_out_data.
  - out_data holds its value until the next routed output.
  - cic_out_strobe in IDLE is ignored.
  - out_strobe is one-hot or zero.
- Overrun:
  - overrun[i] stays set until clear_overrun=1.
  - If clear_overrun and a new overrun event land in the same cycle, set wins.
- Throughput: aggregate input rate must be <= F_clock/GAP. With this met and inputs evenly staggered, overrun stays 0.

Test Plan:
- Reset, then a single sample: NCH=4, GAP=27, in_strobe[2] at cycle 10 with data 0x123456 -> cic_strobe at cycle 12, cic_data=0x123456, cic_chan=2 held through cycle 38; overrun=0.
- Simultaneous requests: in_strobe=4'b1111 in one cycle with rr_ptr=0 -> cic_strobe at cycles k, k+27, k+54, k+81 with cic_chan 0,1,2,3 respectively, and data matching each channel's sample.
- Fairness: channel 0 strobes every 27 cycles while channels 1 and 3 each strobe once -> channels 1 and 3 are granted within 3 slots; channel 0 is never granted twice in a row while another channel is pending.
- Overrun: in_strobe[1] twice, 5 cycles apart, while channel 1 waits behind channel 0 -> the later sample is issued, overrun[1]=1 until a clear_overrun pulse, after which overrun=0.
- Output routing: model engine asserts cic_out_strobe with 0xFEDCBA 20 cycles after a channel-3 issue -> next cycle out_strobe=4'b1000 and out_data=0xFEDCBA; a stray cic_out_strobe in IDLE -> out_strobe stays 0.
- Reset mid-WAIT: reset_n=0 at issue+5 -> all outputs return to their reset values, pending bits clear, and the next request is issued 2 cycles after its in_strobe.
